// File: rtl/port_arb_pkg.sv
// -----------------------------------------------------------------------------
// port_arb_pkg
//   Shared types and helpers for the port round-robin arbiter.
//   - arb_state_e    : arbiter FSM state (IDLE / BUSY)
//   - idxw()         : width of a binary port index, max(1, clog2(n))
//   - idx_to_onehot(): binary index -> one-hot vector (MAX_PORTS wide)
//   - onehot_to_idx(): one-hot vector -> binary index (MAX_PORTS wide)
// -----------------------------------------------------------------------------
package port_arb_pkg;

  localparam int MAX_PORTS = 64;
  localparam int MAX_IDXW  = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Width needed to hold an index in 0..n-1, never less than one bit.
  function automatic int idxw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_PORTS-1:0] idx_to_onehot(input logic [MAX_IDXW-1:0] idx);
    return {{(MAX_PORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // OR-reduction of the set bit positions; exact for a one-hot input.
  function automatic logic [MAX_IDXW-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    logic [MAX_IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | MAX_IDXW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-base priority encoder. Returns the first asserted
//   request at or above 'base', wrapping around to index 0 if none is found.
//   With base tied to 0 it degenerates into a lowest-index-wins encoder.
//
//   Ports
//     req   [PORTNUM]  request vector
//     base  [IDXW]     index where the search starts
//     win   [PORTNUM]  one-hot winner (0 when no request)
//     valid            at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick
  import port_arb_pkg::*;
#(
  parameter  int PORTNUM = 16,
  localparam int IDXW    = idxw(PORTNUM)
) (
  input  logic [PORTNUM-1:0] req,
  input  logic [IDXW-1:0]    base,
  output logic [PORTNUM-1:0] win,
  output logic               valid
);

  logic [MAX_PORTS-1:0] base_oh;
  logic [PORTNUM-1:0]   upper_mask;
  logic [PORTNUM-1:0]   upper_req;
  logic [PORTNUM-1:0]   sel;

  always_comb begin
    base_oh    = idx_to_onehot(MAX_IDXW'(base));
    // Thermometer mask: ones at positions >= base.
    upper_mask = PORTNUM'(~(base_oh - 64'd1));
    upper_req  = req & upper_mask;
    // Requests at/above base take precedence; otherwise wrap to the bottom.
    sel        = (|upper_req) ? upper_req : req;
    // Isolate the lowest set bit of the chosen half.
    win        = sel & (~sel + PORTNUM'(1));
    valid      = |req;
  end

endmodule

// File: rtl/port_rr_arbiter.sv
// -----------------------------------------------------------------------------
// port_rr_arbiter
//   Packet-level arbiter for PORTNUM requesters. In IDLE it picks a winner
//   (round-robin or fixed priority), pulses o_resp for one cycle and holds
//   ownership in o_grant until i_eop or an optional timeout releases it.
//
//   Handshake: a port raises i_req as a level. A grant is taken on the edge
//   where the arbiter is IDLE (o_port_ready=1) and at least one i_req is set;
//   that edge produces a one-cycle o_resp pulse and loads o_grant/o_grant_idx.
//   The owner then keeps the bus until it signals i_eop (sampled only while
//   BUSY) or the timeout fires. Requests are not looked at while BUSY, and
//   every release is followed by at least one IDLE cycle before the next grant.
//
//   Parameters
//     PORTNUM  number of requesting ports (2..64)
//     RR_EN    1 = round-robin, 0 = fixed priority (lowest index wins)
//     TIMEOUT  BUSY cycles before forced release; 0 disables
//
//   Ports
//     i_clk         clock, rising edge
//     i_rst         synchronous active-high reset
//     i_req         per-port request level
//     i_eop         end of packet from the current owner
//     o_port_ready  arbiter idle (decoded from the state register)
//     o_resp        one-hot, one-cycle grant pulse
//     o_nresp       bitwise inverse of o_resp
//     o_grant       one-hot owner, 0 while idle
//     o_grant_idx   binary owner index, holds while idle
//     o_timeout     one-cycle pulse on forced release
//     o_dbg_state   current FSM state for observation
// -----------------------------------------------------------------------------
module port_rr_arbiter
  import port_arb_pkg::*;
#(
  parameter  int PORTNUM = 16,
  parameter  int RR_EN   = 1,
  parameter  int TIMEOUT = 0,
  localparam int IDXW    = idxw(PORTNUM)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PORTNUM-1:0] i_req,
  input  logic               i_eop,
  output logic               o_port_ready,
  output logic [PORTNUM-1:0] o_resp,
  output logic [PORTNUM-1:0] o_nresp,
  output logic [PORTNUM-1:0] o_grant,
  output logic [IDXW-1:0]    o_grant_idx,
  output logic               o_timeout,
  output arb_state_e         o_dbg_state
);

  // Counter is wide enough to hold TIMEOUT; it saturates at all ones.
  localparam int                CNTW     = idxw(TIMEOUT + 1);
  localparam bit                TO_EN    = (TIMEOUT > 0);
  localparam logic [CNTW-1:0]   CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(PORTNUM - 1);

  arb_state_e         state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [PORTNUM-1:0] resp_d;
  logic [PORTNUM-1:0] grant_d;
  logic [IDXW-1:0]    idx_d;
  logic               timeout_d;

  logic [IDXW-1:0]    base;
  logic [PORTNUM-1:0] win;
  logic               win_valid;
  logic [IDXW-1:0]    win_idx;
  logic [IDXW-1:0]    ptr_next;

  // Fixed priority is the same encoder searching from index 0.
  assign base = (RR_EN != 0) ? ptr_q : '0;

  rr_pick #(
    .PORTNUM (PORTNUM)
  ) u_pick (
    .req   (i_req),
    .base  (base),
    .win   (win),
    .valid (win_valid)
  );

  assign win_idx  = IDXW'(onehot_to_idx(64'(win)));
  // (k+1) mod PORTNUM without a divider.
  assign ptr_next = (win_idx == IDX_LAST) ? '0 : win_idx + IDXW'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    resp_d    = '0;
    grant_d   = o_grant;
    idx_d     = o_grant_idx;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_BUSY;
          resp_d  = win;
          grant_d = win;
          idx_d   = win_idx;
          ptr_d   = ptr_next;
          cnt_d   = '0;
        end
      end

      ST_BUSY: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
        // eop wins over a coincident timeout, so no pulse in that case.
        if (i_eop) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      o_resp      <= '0;
      o_nresp     <= '1;
      o_grant     <= '0;
      o_grant_idx <= '0;
      o_timeout   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      o_resp      <= resp_d;
      o_nresp     <= ~resp_d;
      o_grant     <= grant_d;
      o_grant_idx <= idx_d;
      o_timeout   <= timeout_d;
    end
  end

  assign o_port_ready = (state_q == ST_IDLE);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_port_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_port_rr_arbiter
//   Three arbiter instances share clock and reset:
//     d=0  PORTNUM=4,  RR_EN=0, TIMEOUT=0
//     d=1  PORTNUM=4,  RR_EN=1, TIMEOUT=5
//     d=2  PORTNUM=16, RR_EN=1, TIMEOUT=0
//   Directed scenarios use constant expectations; random traffic is checked
//   against a packet-level model that picks winners by scanning port indices.
// -----------------------------------------------------------------------------
module tb_port_rr_arbiter;
  import port_arb_pkg::*;

  localparam int N_A  [3] = '{4, 4, 16};
  localparam int RR_A [3] = '{0, 1, 1};
  localparam int TO_A [3] = '{0, 5, 0};

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus and observation views ----------------
  logic [63:0] v_req [3];
  logic        v_eop [3];

  logic [3:0]  f_resp, f_nresp, f_grant, r_resp, r_nresp, r_grant;
  logic [1:0]  f_idx, r_idx;
  logic        f_ready, f_to, r_ready, r_to;
  arb_state_e  f_st, r_st, b_st;
  logic [15:0] b_resp, b_nresp, b_grant;
  logic [3:0]  b_idx;
  logic        b_ready, b_to;

  logic [63:0] v_resp [3];
  logic [63:0] v_nresp[3];
  logic [63:0] v_grant[3];
  int          v_idx  [3];
  logic        v_ready[3];
  logic        v_to   [3];
  logic        v_busy [3];

  always_comb begin
    v_resp[0] = 64'(f_resp);  v_nresp[0] = 64'(f_nresp); v_grant[0] = 64'(f_grant);
    v_idx[0]  = int'(f_idx);  v_ready[0] = f_ready;       v_to[0]    = f_to;
    v_busy[0] = (f_st == ST_BUSY);
    v_resp[1] = 64'(r_resp);  v_nresp[1] = 64'(r_nresp); v_grant[1] = 64'(r_grant);
    v_idx[1]  = int'(r_idx);  v_ready[1] = r_ready;       v_to[1]    = r_to;
    v_busy[1] = (r_st == ST_BUSY);
    v_resp[2] = 64'(b_resp);  v_nresp[2] = 64'(b_nresp); v_grant[2] = 64'(b_grant);
    v_idx[2]  = int'(b_idx);  v_ready[2] = b_ready;       v_to[2]    = b_to;
    v_busy[2] = (b_st == ST_BUSY);
  end

  port_rr_arbiter #(.PORTNUM(4), .RR_EN(0), .TIMEOUT(0)) u_fix (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(v_req[0][3:0]), .i_eop(v_eop[0]),
    .o_port_ready(f_ready), .o_resp(f_resp), .o_nresp(f_nresp), .o_grant(f_grant),
    .o_grant_idx(f_idx), .o_timeout(f_to), .o_dbg_state(f_st)
  );

  port_rr_arbiter #(.PORTNUM(4), .RR_EN(1), .TIMEOUT(5)) u_rr (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(v_req[1][3:0]), .i_eop(v_eop[1]),
    .o_port_ready(r_ready), .o_resp(r_resp), .o_nresp(r_nresp), .o_grant(r_grant),
    .o_grant_idx(r_idx), .o_timeout(r_to), .o_dbg_state(r_st)
  );

  port_rr_arbiter #(.PORTNUM(16), .RR_EN(1), .TIMEOUT(0)) u_big (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(v_req[2][15:0]), .i_eop(v_eop[2]),
    .o_port_ready(b_ready), .o_resp(b_resp), .o_nresp(b_nresp), .o_grant(b_grant),
    .o_grant_idx(b_idx), .o_timeout(b_to), .o_dbg_state(b_st)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit busy;   // a packet currently owns the arbiter
    int owner;  // owning port
    int ptr;    // next port to be searched first
    int nbusy;  // busy cycles already completed in this packet
    int idx;    // last granted port
    bit resp;   // a grant was issued at the last edge
    bit to;     // a forced release happened at the last edge
  } mdl_t;

  mdl_t m[3];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.busy = 0; r.owner = 0; r.ptr = 0; r.nbusy = 0; r.idx = 0; r.resp = 0; r.to = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input logic [63:0] req, input logic eop,
                                    input int n, input int rr, input int tmo);
    mdl_t r;
    int   j;
    r = s; r.resp = 0; r.to = 0;
    if (!s.busy) begin
      for (int k = 0; k < n; k++) begin
        j = (rr != 0) ? (s.ptr + k) % n : k;
        if (req[j]) begin
          r.busy = 1; r.owner = j; r.idx = j; r.resp = 1; r.ptr = (j + 1) % n; r.nbusy = 0;
          break;
        end
      end
    end else begin
      r.nbusy = s.nbusy + 1;
      if (eop) r.busy = 0;
      else if (tmo > 0 && r.nbusy == tmo) begin r.busy = 0; r.to = 1; end
    end
    return r;
  endfunction

  function automatic logic [63:0] pmask(input int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  // ---------------- driver ----------------
  // Advance every model with the inputs about to be sampled, then step.
  task automatic tick();
    for (int d = 0; d < 3; d++)
      m[d] = i_rst ? mdl_reset() : mdl_step(m[d], v_req[d], v_eop[d], N_A[d], RR_A[d], TO_A[d]);
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      v_req[d] = {$urandom, $urandom} & pmask(N_A[d]);
      v_eop[d] = 1'($urandom_range(0, 1));
    end
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      checks++; if (v_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready d%0d got %b want 1", d, v_ready[d]); end
      checks++; if (v_busy[d] !== 1'b0) begin errors++; $display("FAIL reset_state d%0d got %b want 0", d, v_busy[d]); end
      checks++; if (v_resp[d] !== 64'd0) begin errors++; $display("FAIL reset_resp d%0d got %h want 0", d, v_resp[d]); end
      checks++; if (v_nresp[d] !== pmask(N_A[d])) begin errors++; $display("FAIL reset_nresp d%0d got %h want %h", d, v_nresp[d], pmask(N_A[d])); end
      checks++; if (v_grant[d] !== 64'd0) begin errors++; $display("FAIL reset_grant d%0d got %h want 0", d, v_grant[d]); end
      checks++; if (v_idx[d] !== 0) begin errors++; $display("FAIL reset_idx d%0d got %0d want 0", d, v_idx[d]); end
      checks++; if (v_to[d] !== 1'b0) begin errors++; $display("FAIL reset_timeout d%0d got %b want 0", d, v_to[d]); end
    end
    for (int d = 0; d < 3; d++) begin v_req[d] = '0; v_eop[d] = 1'b0; end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_fixed();
    v_req[0] = 64'b1010; tick();
    checks++; if (f_resp !== 4'b0010) begin errors++; $display("FAIL fix_resp got %b want 0010", f_resp); end
    checks++; if (f_nresp !== 4'b1101) begin errors++; $display("FAIL fix_nresp got %b want 1101", f_nresp); end
    checks++; if (f_idx !== 2'd1) begin errors++; $display("FAIL fix_idx got %0d want 1", f_idx); end
    checks++; if (f_ready !== 1'b0) begin errors++; $display("FAIL fix_ready got %b want 0", f_ready); end
    checks++; if (f_grant !== 4'b0010) begin errors++; $display("FAIL fix_grant got %b want 0010", f_grant); end
    // Owner drops and another port asks: both ignored while busy.
    v_req[0] = 64'b0100; tick();
    checks++; if (f_resp !== 4'b0000) begin errors++; $display("FAIL fix_pulse_len got %b want 0000", f_resp); end
    checks++; if (f_grant !== 4'b0010) begin errors++; $display("FAIL fix_hold got %b want 0010", f_grant); end
    v_eop[0] = 1'b1; tick();
    checks++; if (f_ready !== 1'b1) begin errors++; $display("FAIL fix_release got %b want 1", f_ready); end
    checks++; if (f_grant !== 4'b0000) begin errors++; $display("FAIL fix_grant_clr got %b want 0000", f_grant); end
    checks++; if (f_idx !== 2'd1) begin errors++; $display("FAIL fix_idx_hold got %0d want 1", f_idx); end
    // eop while idle is ignored.
    v_req[0] = '0; tick();
    checks++; if (f_ready !== 1'b1) begin errors++; $display("FAIL fix_idle_eop got %b want 1", f_ready); end
    v_eop[0] = 1'b0; v_req[0] = 64'b1100; tick();
    checks++; if (f_idx !== 2'd2) begin errors++; $display("FAIL fix_second_idx got %0d want 2", f_idx); end
    v_eop[0] = 1'b1; v_req[0] = '0; tick();
    v_eop[0] = 1'b0;
  endtask

  task automatic test_rr_order();
    v_req[1] = 64'hF;
    for (int g = 0; g < 5; g++) begin
      v_eop[1] = 1'b0; tick();
      checks++; if (v_resp[1] !== (64'd1 << (g % 4))) begin errors++; $display("FAIL rr_order_resp g%0d got %h want %h", g, v_resp[1], 64'd1 << (g % 4)); end
      checks++; if (v_idx[1] !== g % 4) begin errors++; $display("FAIL rr_order_idx g%0d got %0d want %0d", g, v_idx[1], g % 4); end
      checks++; if (v_ready[1] !== 1'b0) begin errors++; $display("FAIL rr_order_busy g%0d got %b want 0", g, v_ready[1]); end
      v_eop[1] = 1'b1; tick();
      checks++; if (v_ready[1] !== 1'b1) begin errors++; $display("FAIL rr_order_gap g%0d got %b want 1", g, v_ready[1]); end
      checks++; if (v_grant[1] !== 64'd0) begin errors++; $display("FAIL rr_order_clr g%0d got %h want 0", g, v_grant[1]); end
    end
    v_eop[1] = 1'b0; v_req[1] = '0; tick();
  endtask

  task automatic test_wrap();
    v_req[1] = 64'b0100; tick();
    checks++; if (v_idx[1] !== 2) begin errors++; $display("FAIL wrap_setup got %0d want 2", v_idx[1]); end
    v_eop[1] = 1'b1; tick(); v_eop[1] = 1'b0;
    v_req[1] = 64'b0001; tick();
    checks++; if (v_idx[1] !== 0) begin errors++; $display("FAIL wrap_idx got %0d want 0", v_idx[1]); end
    checks++; if (v_resp[1] !== 64'b0001) begin errors++; $display("FAIL wrap_resp got %h want 1", v_resp[1]); end
    v_eop[1] = 1'b1; tick(); v_eop[1] = 1'b0;
    v_req[1] = 64'hF; tick();
    checks++; if (v_idx[1] !== 1) begin errors++; $display("FAIL wrap_ptr got %0d want 1", v_idx[1]); end
    v_eop[1] = 1'b1; v_req[1] = '0; tick(); v_eop[1] = 1'b0;
  endtask

  task automatic test_timeout();
    v_req[1] = 64'b0100; tick();
    checks++; if (v_idx[1] !== 2) begin errors++; $display("FAIL to_grant got %0d want 2", v_idx[1]); end
    v_req[1] = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (v_ready[1] !== 1'b0 || v_to[1] !== 1'b0) begin errors++; $display("FAIL to_early c%0d got ready=%b to=%b want 0 0", c, v_ready[1], v_to[1]); end
      checks++; if (v_grant[1] !== 64'b0100) begin errors++; $display("FAIL to_hold c%0d got %h want 4", c, v_grant[1]); end
    end
    tick();
    checks++; if (v_to[1] !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", v_to[1]); end
    checks++; if (v_ready[1] !== 1'b1) begin errors++; $display("FAIL to_idle got %b want 1", v_ready[1]); end
    checks++; if (v_grant[1] !== 64'd0) begin errors++; $display("FAIL to_grant_clr got %h want 0", v_grant[1]); end
    checks++; if (v_idx[1] !== 2) begin errors++; $display("FAIL to_idx_hold got %0d want 2", v_idx[1]); end
    tick();
    checks++; if (v_to[1] !== 1'b0) begin errors++; $display("FAIL to_pulse_len got %b want 0", v_to[1]); end
    // Same again, but eop lands in the fifth busy cycle.
    v_req[1] = 64'b1000; tick();
    checks++; if (v_idx[1] !== 3) begin errors++; $display("FAIL to_eop_grant got %0d want 3", v_idx[1]); end
    v_req[1] = '0;
    for (int c = 0; c < 4; c++) tick();
    v_eop[1] = 1'b1; tick();
    checks++; if (v_to[1] !== 1'b0) begin errors++; $display("FAIL to_eop_nopulse got %b want 0", v_to[1]); end
    checks++; if (v_ready[1] !== 1'b1) begin errors++; $display("FAIL to_eop_idle got %b want 1", v_ready[1]); end
    v_eop[1] = 1'b0; tick();
    checks++; if (v_to[1] !== 1'b0) begin errors++; $display("FAIL to_eop_after got %b want 0", v_to[1]); end
  endtask

  task automatic test_reset_mid_packet();
    v_req[1] = 64'b0100; tick();
    checks++; if (v_idx[1] !== 2) begin errors++; $display("FAIL rst_mid_setup got %0d want 2", v_idx[1]); end
    v_req[1] = 64'hF; i_rst = 1'b1; tick();
    checks++; if (v_grant[1] !== 64'd0) begin errors++; $display("FAIL rst_mid_grant got %h want 0", v_grant[1]); end
    checks++; if (v_ready[1] !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", v_ready[1]); end
    checks++; if (v_resp[1] !== 64'd0 || v_to[1] !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got resp=%h to=%b want 0 0", v_resp[1], v_to[1]); end
    checks++; if (v_idx[1] !== 0) begin errors++; $display("FAIL rst_mid_idx got %0d want 0", v_idx[1]); end
    i_rst = 1'b0; tick();
    checks++; if (v_resp[1] !== 64'b0001) begin errors++; $display("FAIL rst_regrant_resp got %h want 1", v_resp[1]); end
    checks++; if (v_grant[1] !== 64'b0001) begin errors++; $display("FAIL rst_regrant_grant got %h want 1", v_grant[1]); end
    v_eop[1] = 1'b1; v_req[1] = '0; tick(); v_eop[1] = 1'b0;
  endtask

  task automatic test_random(input int d, input int cycles, input int eop_den);
    int          wait_cnt[64];
    int          worst;
    logic [63:0] req;
    logic [63:0] exp_resp;
    logic [63:0] exp_grant;
    for (int j = 0; j < 64; j++) wait_cnt[j] = 0;
    for (int c = 0; c < cycles; c++) begin
      case ($urandom_range(0, 3))
        0:       req = '0;
        1:       req = {$urandom, $urandom};
        default: req = {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      req      = req & pmask(N_A[d]);
      v_req[d] = req;
      v_eop[d] = ($urandom_range(0, eop_den - 1) == 0);
      tick();
      exp_resp  = m[d].resp ? (64'd1 << m[d].idx) : 64'd0;
      exp_grant = m[d].busy ? (64'd1 << m[d].owner) : 64'd0;
      checks++; if (v_ready[d] !== !m[d].busy) begin errors++; $display("FAIL rnd_ready d%0d c%0d got %b want %b", d, c, v_ready[d], !m[d].busy); end
      checks++; if (v_busy[d] !== m[d].busy) begin errors++; $display("FAIL rnd_state d%0d c%0d got %b want %b", d, c, v_busy[d], m[d].busy); end
      checks++; if (v_grant[d] !== exp_grant) begin errors++; $display("FAIL rnd_grant d%0d c%0d got %h want %h", d, c, v_grant[d], exp_grant); end
      checks++; if (v_idx[d] !== m[d].idx) begin errors++; $display("FAIL rnd_idx d%0d c%0d got %0d want %0d", d, c, v_idx[d], m[d].idx); end
      checks++; if (v_resp[d] !== exp_resp) begin errors++; $display("FAIL rnd_resp d%0d c%0d got %h want %h", d, c, v_resp[d], exp_resp); end
      checks++; if (v_nresp[d] !== (~exp_resp & pmask(N_A[d]))) begin errors++; $display("FAIL rnd_nresp d%0d c%0d got %h want %h", d, c, v_nresp[d], ~exp_resp & pmask(N_A[d])); end
      checks++; if (v_to[d] !== m[d].to) begin errors++; $display("FAIL rnd_timeout d%0d c%0d got %b want %b", d, c, v_to[d], m[d].to); end
      checks++; if ($countones(v_grant[d]) > 1) begin errors++; $display("FAIL rnd_onehot d%0d c%0d got %h want one-hot or 0", d, c, v_grant[d]); end
      // Starvation: a port that keeps asking at every decision loses fewer than PORTNUM times.
      if (RR_A[d] != 0 && v_resp[d] != 64'd0) begin
        worst = 0;
        for (int j = 0; j < N_A[d]; j++) begin
          if (req[j] && j != v_idx[d]) wait_cnt[j]++;
          else wait_cnt[j] = 0;
          if (wait_cnt[j] > worst) worst = wait_cnt[j];
        end
        checks++; if (worst >= N_A[d]) begin errors++; $display("FAIL rnd_starve d%0d c%0d got %0d want < %0d", d, c, worst, N_A[d]); end
      end
    end
    v_req[d] = '0; v_eop[d] = 1'b1; tick();
    v_eop[d] = 1'b0; tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      v_req[d] = '0;
      v_eop[d] = 1'b0;
      m[d]     = mdl_reset();
    end
    test_reset();
    test_fixed();
    test_rr_order();
    test_wrap();
    test_timeout();
    test_reset_mid_packet();
    test_random(2, 3000, 4);
    test_random(1, 1500, 8);
    test_random(0, 500, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_rr_arbiter.md
PORT_RR_ARBITER -- requirements
Module: port_rr_arbiter

Interface
REQ-001 Parameter PORTNUM, default 16, SHALL set the number of requesting ports (2..64).
REQ-002 Parameter RR_EN, default 1, SHALL select round-robin when 1 and fixed priority (lowest index wins) when 0.
REQ-003 Parameter TIMEOUT, default 0, SHALL set the maximum BUSY cycles before forced release; 0 disables the timeout.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_req  input  PORTNUM  per-port request level.
REQ-007 i_eop  input  1  end of packet of the granted port.
REQ-008 o_port_ready  output  1  high when the arbiter is idle.
REQ-009 o_resp  output  PORTNUM  one-hot, one-cycle grant pulse.
REQ-010 o_nresp  output  PORTNUM  bitwise inverse of o_resp.
REQ-011 o_grant  output  PORTNUM  one-hot owner, held for the whole packet.
REQ-012 o_grant_idx  output  IDXW  binary index of the owner; IDXW = max(1, clog2(PORTNUM)).
REQ-013 o_timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 FSM states SHALL be IDLE and BUSY.
REQ-015 IDLE with i_req != 0 SHALL move to BUSY on the next edge.
- Same edge: o_resp = one-hot of the winner for exactly one cycle.
- Same edge: o_grant and o_grant_idx load the winner.
REQ-016 IDLE with i_req == 0 SHALL stay IDLE; i_eop in IDLE is ignored.
REQ-017 BUSY with i_eop = 1 SHALL return to IDLE on the next edge and clear o_grant to 0.
REQ-018 BUSY SHALL ignore all i_req changes, including the owner dropping its request.
REQ-019 A minimum of one IDLE cycle SHALL separate consecutive grants.
REQ-020 o_port_ready SHALL equal (state == IDLE), combinationally from the state register.
REQ-021 Fixed mode SHALL select the lowest-index asserted request.
REQ-022 Round-robin mode SHALL search upward from pointer ptr with wrap-around.
- Select the first asserted index.
- On each grant to index k: ptr <= (k+1) mod PORTNUM.
REQ-023 The BUSY counter SHALL clear on entry to BUSY and increment each BUSY cycle, saturating.
REQ-024 When TIMEOUT > 0 and the count reaches TIMEOUT-1 without i_eop, the block SHALL return to IDLE next edge and pulse o_timeout for one cycle.
REQ-025 i_eop and the timeout in the same cycle SHALL be treated as eop; no o_timeout pulse.
REQ-026 o_nresp SHALL be ~o_resp in every cycle, including reset.
REQ-027 o_grant_idx SHALL hold its last value while idle; o_grant SHALL be 0 while idle.

Reset
REQ-028 While i_rst = 1, outputs SHALL take these values at the next edge, regardless of state:
- state = IDLE, ptr = 0, counter = 0.
- o_resp = 0, o_nresp = all ones, o_grant = 0, o_grant_idx = 0, o_timeout = 0.
REQ-029 Reset mid-packet SHALL abandon the grant without any o_resp or o_timeout pulse.

Structure
REQ-030 Package port_arb_pkg SHALL hold:
- the state enum (IDLE, BUSY);
- the IDXW helper function;
- the one-hot/index conversion functions.
REQ-031 Combinational winner selection (rotating-base priority encoder) SHALL be the sub-module rr_pick, parametrised by PORTNUM; fixed mode drives base = 0.
REQ-032 All outputs except o_port_ready SHALL be registered.

Verification (PORTNUM=4 unless noted)
REQ-033 RR_EN=0: i_req=4'b1010 in IDLE -> next cycle o_resp=4'b0010, o_nresp=4'b1101, o_grant_idx=1, o_port_ready=0.
REQ-034 RR_EN=1: i_req=4'b1111 held, eop after each grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-035 RR_EN=1: ptr=3, i_req=4'b0001 -> wrap-around grant to 0, ptr becomes 1.
REQ-036 TIMEOUT=5: grant, no eop -> o_timeout pulses one cycle, state IDLE after 5 BUSY cycles; repeat with i_eop in the 5th cycle -> no pulse.
REQ-037 i_rst asserted in BUSY with i_req held -> next cycle o_grant=0, o_port_ready=1, no pulses; regrant to index 0 after release.
REQ-038 PORTNUM=16, random req/eop -> o_grant always one-hot or zero, o_nresp==~o_resp every cycle, no starvation beyond 16 grants.
